zxw_alu_op_sequencer: RTL
=========================

# zxw_alu_op_sequencer

Sequential command front-end for the 4-bit `zxw_alu_logic_verilog` unit.
- Accepts one ALU command per valid/ready handshake and drives the logic unit's `fs2`/`fs1`/`A`/`B` from registers.
- Captures the 5-bit `fun` result. For the shift op it iterates the unit 1–4 times, feeding the shifted nibble back as the next `A`.
- Presents the final result on a valid/ready output. Sits between the datapath controller and the combinational logic unit.

## Interface
- `CNT_W`, default 2: width of the shift-iteration count; number of shifts = `cmd_count`+1.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_fs`  in  2  op select, `{fs2,fs1}`: 00 NOT A, 01 A&B, 10 A|B, 11 shift right.
- `cmd_a`, `cmd_b`  in  4 each  operands.
- `cmd_count`  in  `CNT_W`  shift iterations minus one; ignored unless `cmd_fs`=11.
- `alu_fs2`, `alu_fs1`  out  1 each  registered op select to the logic unit.
- `alu_a`, `alu_b`  out  4 each  registered operands to the logic unit.
- `alu_fun`  in  5  combinational result from the logic unit.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  5  captured result.

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`: load `alu_fs2`/`alu_fs1`/`alu_a`/`alu_b` from the command and load `iter` = `cmd_count` for shift, 0 otherwise.
  - Go to EXEC.
- EXEC:
  - Logic unit evaluates the registered operands combinationally.
  - Each cycle, `res_data` ← `alu_fun`.
  - If `iter`=0, go to DONE.
  - Otherwise `alu_a` ← `alu_fun[3:0]` and `iter` ← `iter`−1; `alu_b` and the op select are unchanged.
- DONE:
  - `res_valid`=1 and `res_data` is held stable.
  - On `res_ready`, go to IDLE. There is no overlap: the next command is accepted only after returning to IDLE.
- `cmd_ready` is a decode of state==IDLE. `res_valid` is a decode of state==DONE.
- Shift semantics are the unit's own: `fun[4]` = `A[0]`, `fun[3:0]` = `{A[3],A[3:1]}`. Iterated shifts keep only the last shifted-out bit in `res_data[4]`.
- NOT result is the unit's 5-bit `~A`, so bit 4 = 1.
- `cmd_*` inputs are sampled only in IDLE with `cmd_valid`=1. Changes at any other time are ignored.

## Timing
- Reset values:
  - state IDLE, `cmd_ready`=1.
  - `res_valid`=0, `res_data`=0.
  - `alu_fs2`=0, `alu_fs1`=0, `alu_a`=0, `alu_b`=0.
  - `iter`=0.
- Latency: command accepted at edge 0.
  - Logic ops: EXEC spans 1 cycle; `res_valid` rises after edge 2.
  - Shift with count c: EXEC spans c+1 cycles; `res_valid` rises after edge c+2.
- Throughput: one command per (EXEC length + 2) cycles when `res_ready` is held high.
- Backpressure: `res_ready`=0 holds DONE indefinitely with `res_data` stable and `cmd_ready`=0.
- Simultaneous `cmd_valid` in DONE: ignored; the command must be re-presented in IDLE.
- `rst_n` asserted mid-EXEC or mid-DONE: immediate return to reset values and the pending result is discarded.

## Configuration
- `ZXW_SEQ_ZERO_FLAG_EN` defined:
  - Adds output `res_zero` (1 bit), registered with `res_data`; it is 1 when `alu_fun[3:0]`==0 at the final capture.
  - Reset value 0; valid only while `res_valid`=1.
- Not defined: no `res_zero` port and no related logic.

## Structure
- Shared package `zxw_alu_pkg`:
  - op-code constants `OP_NOT`=2'b00, `OP_AND`=2'b01, `OP_OR`=2'b10, `OP_SHR`=2'b11.
  - state encoding typedef.
  - result width constant 5.
- No sub-module inside the sequencer. The logic unit is instantiated alongside it by the parent, or inside the test bench.

## Test plan
- NOT, A=4'b1010 → `res_data`=5'b10101; `res_valid` asserts 2 cycles after accept.
- AND, A=4'b1100, B=4'b1010 → 5'b01000. Then OR with the same operands → 5'b01110.
- Shift, A=4'b1001, count=0 → 5'b11100. Count=1 → 5'b01110, `res_valid` 3 cycles after accept.
- Shift, A=4'b0110, count=3 → 5'b00000, with `res_zero`=1 when `ZXW_SEQ_ZERO_FLAG_EN` is defined. `res_valid` asserts 5 cycles after accept.
- `res_ready` held low 5 cycles in DONE, with `cmd_valid` pulsed:
  - `res_data` stays stable and `cmd_ready` stays 0.
  - The pulsed command is not taken.
  - After `res_ready`, the FSM returns to IDLE.
- `rst_n` pulsed low during the second EXEC cycle of a count=3 shift → all outputs return to reset values and no `res_valid` follows.

Source files
------------

// File: rtl/zxw_alu_pkg.sv
// Purpose: shared op codes, sequencer state encoding and result width for the zxw ALU slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package zxw_alu_pkg;

    // Op select as presented on {fs2,fs1}
    localparam logic [1:0] OP_NOT = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_SHR = 2'b11;

    // Width of the logic unit's fun result
    localparam int RES_W = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } seq_state_e;

endpackage

// File: rtl/zxw_alu_op_sequencer.sv
// Purpose: command front-end for the 4-bit logic unit; registers op/operands, iterates shifts, returns fun.
// Latency: handshake cycle + (1 | cmd_count+1) EXEC cycles, then res_valid in the following cycle.
// Backpressure: res_ready=0 parks in DONE with res_data stable and cmd_ready=0; no command overlap.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake (cmd_fs, cmd_a, cmd_b, cmd_count)
//   alu_fs2/alu_fs1/alu_a/alu_b     registered drive to the combinational logic unit
//   alu_fun                         5-bit combinational result from the logic unit
//   res_valid/res_ready/res_data    result handshake
//   res_zero                        only when ZXW_SEQ_ZERO_FLAG_EN is defined: res_data[3:0]==0
module zxw_alu_op_sequencer
    import zxw_alu_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_fs,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             alu_fs2,
    output logic             alu_fs1,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    input  logic [RES_W-1:0] alu_fun,
    output logic             res_valid,
    input  logic             res_ready,
`ifdef ZXW_SEQ_ZERO_FLAG_EN
    output logic [RES_W-1:0] res_data,
    output logic             res_zero
`else
    output logic [RES_W-1:0] res_data
`endif
);

    seq_state_e       state_q, state_d;
    logic [1:0]       fs_q, fs_d;
    logic [3:0]       a_q, a_d;
    logic [3:0]       b_q, b_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic [RES_W-1:0] res_q, res_d;
`ifdef ZXW_SEQ_ZERO_FLAG_EN
    logic             zero_q, zero_d;
`endif

    always_comb begin
        state_d = state_q;
        fs_d    = fs_q;
        a_d     = a_q;
        b_d     = b_q;
        iter_d  = iter_q;
        res_d   = res_q;
`ifdef ZXW_SEQ_ZERO_FLAG_EN
        zero_d  = zero_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    fs_d    = cmd_fs;
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    // Only the shift op iterates; logic ops always take a single pass
                    iter_d  = (cmd_fs == OP_SHR) ? cmd_count : '0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Captured every pass so the last pass leaves the final result behind
                res_d = alu_fun;
`ifdef ZXW_SEQ_ZERO_FLAG_EN
                zero_d = (alu_fun[3:0] == 4'b0000);
`endif
                if (iter_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    // Feed the shifted nibble back; B and op select stay put
                    a_d    = alu_fun[3:0];
                    iter_d = iter_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            fs_q    <= 2'b00;
            a_q     <= 4'b0000;
            b_q     <= 4'b0000;
            iter_q  <= '0;
            res_q   <= '0;
`ifdef ZXW_SEQ_ZERO_FLAG_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            fs_q    <= fs_d;
            a_q     <= a_d;
            b_q     <= b_d;
            iter_q  <= iter_d;
            res_q   <= res_d;
`ifdef ZXW_SEQ_ZERO_FLAG_EN
            zero_q  <= zero_d;
`endif
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign res_valid = (state_q == S_DONE);
    assign alu_fs2   = fs_q[1];
    assign alu_fs1   = fs_q[0];
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign res_data  = res_q;
`ifdef ZXW_SEQ_ZERO_FLAG_EN
    assign res_zero  = zero_q;
`endif

endmodule
